// File: rtl/barra_pkg.sv
// Shared paddle definitions: FSM state type, screen limits and the derived
// x_barra clamp range used by both this controller and the paddle renderer.
package barra_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_L = 2'd1,
      MOVE_R = 2'd2
   } barra_state_t;

   localparam int X_W            = 11;
   localparam int PADDLE_W       = 170;
   localparam int H_ACTIVE_START = 97;
   localparam int H_ACTIVE_END   = 736;

   // x_barra is the right edge, so the leftmost legal value keeps the
   // paddle's left edge on the first visible column.
   localparam int X_MIN = H_ACTIVE_START + PADDLE_W - 1;
   localparam int X_MAX = H_ACTIVE_END;

endpackage

// File: rtl/barra_ctrl_if.sv
// Paddle controller bus: game-side controls and frame timing in, paddle
// position and status out.
interface barra_ctrl_if;
   import barra_pkg::*;

   logic             enable;
   logic             btn_left;
   logic             btn_right;
   logic [9:0]       v_counter;
   logic [X_W-1:0]   x_barra;
   logic             moving;
   logic             hit_wall;

   modport master (
      output enable, btn_left, btn_right, v_counter,
      input  x_barra, moving, hit_wall
   );

   modport slave (
      input  enable, btn_left, btn_right, v_counter,
      output x_barra, moving, hit_wall
   );

endinterface

// File: rtl/barra_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer followed by a stable-count filter.
// The accepted level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
module btn_debounce
   import barra_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] stable_cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   // Count consecutive disagreeing cycles and accept the new level at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_cnt <= '0;
         btn_level  <= 1'b0;
      end else if (sync_p1 == btn_level) begin
         stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable_cnt <= '0;
         btn_level  <= sync_p1;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/barra_ctrl.sv
// Paddle position writer: debounced buttons drive a per-frame FSM with
// acceleration; x_barra only changes on the frame tick (line 0) so the
// renderer sees a stable value for the whole active video.
module barra_ctrl
   import barra_pkg::*;
#(
   parameter int X_RESET         = 501,
   parameter int STEP_MIN        = 2,
   parameter int STEP_MAX        = 8,
   parameter int ACCEL_FRAMES    = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic         clk,
   input  logic         reset,
   barra_ctrl_if.slave  bus
);

   localparam int STEP_W = $clog2(STEP_MAX + 1);
   localparam int FCNT_W = $clog2(ACCEL_FRAMES + 1);
   localparam logic [X_W:0] X_MIN_E = (X_W + 1)'(X_MIN);
   localparam logic [X_W:0] X_MAX_E = (X_W + 1)'(X_MAX);

   logic               btn_l_db;
   logic               btn_r_db;
   logic [9:0]         v_prev;
   logic               tick;
   logic               go_l;
   logic               go_r;
   barra_state_t       state_q;
   barra_state_t       state_d;
   logic [STEP_W-1:0]  step_q;
   logic [STEP_W-1:0]  step_d;
   logic [STEP_W-1:0]  step_use;
   logic [FCNT_W-1:0]  fcnt_q;
   logic [FCNT_W-1:0]  fcnt_d;
   logic [FCNT_W-1:0]  fcnt_base;
   logic [X_W-1:0]     x_q;
   logic [X_W-1:0]     x_d;
   logic               hit_d;
   logic               hit_q;
   logic               moving_q;

   // Zero-extend the step into the 12-bit position arithmetic.
   function automatic logic [X_W:0] ext_step(input logic [STEP_W-1:0] s);
      return {{(X_W + 1 - STEP_W){1'b0}}, s};
   endfunction

   // True when moving left by s would cross X_MIN.
   function automatic logic clamps_left(input logic [X_W-1:0] x, input logic [STEP_W-1:0] s);
      return ({1'b0, x} < (X_MIN_E + ext_step(s)));
   endfunction

   // True when moving right by s would cross X_MAX.
   function automatic logic clamps_right(input logic [X_W-1:0] x, input logic [STEP_W-1:0] s);
      return (({1'b0, x} + ext_step(s)) > X_MAX_E);
   endfunction

   // Speed increment saturating at STEP_MAX.
   function automatic logic [STEP_W-1:0] sat_step(input logic [STEP_W-1:0] s);
      return (s >= STEP_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : s + STEP_W'(1);
   endfunction

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (bus.btn_left),
      .btn_level (btn_l_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (bus.btn_right),
      .btn_level (btn_r_db)
   );

   assign tick = (bus.v_counter == 10'd0) && (v_prev != 10'd0);
   assign go_l = btn_l_db & ~btn_r_db;
   assign go_r = btn_r_db & ~btn_l_db;

   assign bus.x_barra  = x_q;
   assign bus.moving   = moving_q;
   assign bus.hit_wall = hit_q;

   // Next-state, speed, frame count and position, evaluated only on a frame tick.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      fcnt_d    = fcnt_q;
      x_d       = x_q;
      hit_d     = 1'b0;
      step_use  = step_q;
      fcnt_base = fcnt_q;
      if (tick) begin
         if (!bus.enable) begin
            state_d = IDLE;
            step_d  = STEP_W'(STEP_MIN);
            fcnt_d  = '0;
         end else begin
            case (state_q)
               MOVE_L:  state_d = go_l ? MOVE_L : (go_r ? MOVE_R : IDLE);
               MOVE_R:  state_d = go_r ? MOVE_R : (go_l ? MOVE_L : IDLE);
               default: state_d = go_l ? MOVE_L : (go_r ? MOVE_R : IDLE);
            endcase
            // Starting from rest or reversing begins again at the slowest speed.
            if (state_d != state_q) begin
               step_use  = STEP_W'(STEP_MIN);
               fcnt_base = '0;
            end
            case (state_d)
               MOVE_L: begin
                  hit_d = clamps_left(x_q, step_use);
                  x_d   = hit_d ? X_W'(X_MIN) : X_W'({1'b0, x_q} - ext_step(step_use));
               end
               MOVE_R: begin
                  hit_d = clamps_right(x_q, step_use);
                  x_d   = hit_d ? X_W'(X_MAX) : X_W'({1'b0, x_q} + ext_step(step_use));
               end
               default: x_d = x_q;
            endcase
            if (state_d == IDLE) begin
               step_d = STEP_W'(STEP_MIN);
               fcnt_d = '0;
            end else if (fcnt_base == FCNT_W'(ACCEL_FRAMES - 1)) begin
               step_d = sat_step(step_use);
               fcnt_d = '0;
            end else begin
               step_d = step_use;
               fcnt_d = fcnt_base + FCNT_W'(1);
            end
         end
      end
   end

   // Register FSM, motion state, outputs and the previous line for tick detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         step_q   <= STEP_W'(STEP_MIN);
         fcnt_q   <= '0;
         x_q      <= X_W'(X_RESET);
         hit_q    <= 1'b0;
         moving_q <= 1'b0;
         v_prev   <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         fcnt_q   <= fcnt_d;
         x_q      <= x_d;
         hit_q    <= hit_d;
         moving_q <= (state_d != IDLE);
         v_prev   <= bus.v_counter;
      end
   end

endmodule

// File: tb/tb_barra_ctrl.sv
// Bench for barra_ctrl: short 24-line frames (one clock per line), debounce
// shortened to 4 cycles, and a cycle-level reference model of the paddle rules.
module tb_barra_ctrl;
   import barra_pkg::*;

   localparam int FRAME = 24;
   localparam int DEB   = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   barra_ctrl_if bus ();

   barra_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_run  = 0;
   int n_fail = 0;

   // stimulus state
   bit rst_d = 1'b1;
   bit en_d  = 1'b1;
   bit bl_d  = 1'b0;
   bit br_d  = 1'b0;
   int vc    = 1;

   // reference model state
   int m_x, m_step, m_cnt, m_mode, m_vprev;
   bit m_moving, m_hit, m_tick;
   bit m_lvl [2];
   bit hist [2][5];

   task automatic model_step(input bit r, input bit en, input bit bl, input bit br, input int v);
      int  dir;
      int  t;
      bit  all_diff;
      bit  raw [2];
      if (r) begin
         m_x = 501; m_step = 2; m_cnt = 0; m_mode = 0; m_vprev = 0;
         m_moving = 0; m_hit = 0; m_tick = 0;
         for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 0;
            for (int k = 0; k < 5; k++) hist[b][k] = 0;
         end
         return;
      end
      m_tick = (v == 0) && (m_vprev != 0);
      m_hit  = 0;
      if (m_tick) begin
         dir = (m_lvl[0] && !m_lvl[1]) ? -1 : ((m_lvl[1] && !m_lvl[0]) ? 1 : 0);
         if (!en || dir == 0) begin
            m_mode = 0; m_step = 2; m_cnt = 0;
         end else begin
            if (dir != m_mode) begin m_step = 2; m_cnt = 0; end
            m_mode = dir;
            t = m_x + dir * m_step;
            if (t < 266) begin m_x = 266; m_hit = 1; end
            else if (t > 736) begin m_x = 736; m_hit = 1; end
            else m_x = t;
            m_cnt++;
            if (m_cnt == 4) begin
               m_cnt = 0;
               if (m_step < 8) m_step++;
            end
         end
         m_moving = (m_mode != 0);
      end
      m_vprev = v;
      // a button level is accepted once the input seen two cycles late has
      // disagreed with it on each of the last DEB cycles
      raw[0] = bl; raw[1] = br;
      for (int b = 0; b < 2; b++) begin
         all_diff = 1;
         for (int k = 1; k <= DEB; k++) if (hist[b][k] == m_lvl[b]) all_diff = 0;
         if (all_diff) m_lvl[b] = hist[b][1];
         for (int k = 4; k > 0; k--) hist[b][k] = hist[b][k-1];
         hist[b][0] = raw[b];
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      reset         = rst_d;
      bus.enable    = en_d;
      bus.btn_left  = bl_d;
      bus.btn_right = br_d;
      bus.v_counter = 10'(vc);
      @(posedge clk);
      model_step(rst_d, en_d, bl_d, br_d, vc);
      vc = (vc + 1) % FRAME;
      #1;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 2 * FRAME; i++) begin
         cyc();
         if (m_tick) break;
      end
   endtask

   task automatic do_reset();
      rst_d = 1; cyc(); cyc(); rst_d = 0;
   endtask

   task automatic test_reset();
      rst_d = 1; en_d = 1; bl_d = 0; br_d = 0;
      cyc(); cyc(); cyc();
      rst_d = 0;
      n_run++; if (bus.x_barra !== 11'd501) begin n_fail++; $display("FAIL reset_x: got %0d want 501", bus.x_barra); end
      n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b want 0", bus.moving); end
      n_run++; if (bus.hit_wall !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", bus.hit_wall); end
      for (int i = 0; i < 2; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== 11'd501) begin n_fail++; $display("FAIL idle_x[%0d]: got %0d want 501", i, bus.x_barra); end
      end
   endtask

   task automatic test_right_accel();
      int exp_x [6] = '{503, 505, 507, 509, 512, 515};
      wait_tick();
      br_d = 1;
      for (int i = 0; i < 6; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== 11'(exp_x[i])) begin n_fail++; $display("FAIL accel_x[%0d]: got %0d want %0d", i, bus.x_barra, exp_x[i]); end
         n_run++; if (bus.moving !== 1'b1) begin n_fail++; $display("FAIL accel_moving[%0d]: got %b want 1", i, bus.moving); end
      end
   endtask

   task automatic test_left_wall();
      bit seen_hit = 0;
      br_d = 0; bl_d = 1;
      for (int i = 0; i < 80; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== 11'(m_x)) begin n_fail++; $display("FAIL wall_x[%0d]: got %0d want %0d", i, bus.x_barra, m_x); end
         n_run++; if (bus.hit_wall !== m_hit) begin n_fail++; $display("FAIL wall_hit[%0d]: got %b want %b", i, bus.hit_wall, m_hit); end
         if (m_hit) begin seen_hit = 1; break; end
      end
      n_run++; if (!seen_hit || bus.x_barra !== 11'd266) begin n_fail++; $display("FAIL wall_final: got %0d hit %b want 266 hit 1", bus.x_barra, bus.hit_wall); end
      cyc();
      n_run++; if (bus.hit_wall !== 1'b0) begin n_fail++; $display("FAIL wall_pulse_width: got %b want 0", bus.hit_wall); end
   endtask

   task automatic test_reverse();
      logic [10:0] x_prev;
      bl_d = 0; br_d = 0;
      do_reset();
      br_d = 1;
      for (int i = 0; i < 40 && m_step < 8; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== 11'(m_x)) begin n_fail++; $display("FAIL rev_right_x[%0d]: got %0d want %0d", i, bus.x_barra, m_x); end
      end
      br_d = 0;
      wait_tick(); wait_tick();
      n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL rev_release_moving: got %b want 0", bus.moving); end
      x_prev = bus.x_barra;
      bl_d = 1;
      wait_tick();
      n_run++; if (bus.x_barra !== x_prev - 11'd2) begin n_fail++; $display("FAIL rev_left_first: got %0d want %0d", bus.x_barra, x_prev - 11'd2); end
      x_prev = bus.x_barra;
      br_d = 1;
      wait_tick(); wait_tick();
      n_run++; if (bus.x_barra !== x_prev) begin n_fail++; $display("FAIL both_x: got %0d want %0d", bus.x_barra, x_prev); end
      n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL both_moving: got %b want 0", bus.moving); end
   endtask

   task automatic test_glitch();
      logic [10:0] x0;
      bl_d = 0; br_d = 0;
      wait_tick(); wait_tick();
      x0 = bus.x_barra;
      br_d = 1; cyc(); cyc(); cyc(); br_d = 0;
      for (int i = 0; i < 2; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== x0) begin n_fail++; $display("FAIL glitch3_x[%0d]: got %0d want %0d", i, bus.x_barra, x0); end
         n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL glitch3_moving[%0d]: got %b want 0", i, bus.moving); end
      end
      br_d = 1;
      wait_tick(); wait_tick();
      x0 = bus.x_barra;
      for (int i = 0; i < 5; i++) cyc();
      br_d = 0; cyc(); br_d = 1;
      wait_tick();
      n_run++; if (bus.moving !== 1'b1) begin n_fail++; $display("FAIL glitch1_moving: got %b want 1", bus.moving); end
      n_run++; if (bus.x_barra <= x0 || bus.x_barra !== 11'(m_x)) begin n_fail++; $display("FAIL glitch1_x: got %0d want %0d", bus.x_barra, m_x); end
   endtask

   task automatic test_enable();
      logic [10:0] x0;
      bl_d = 0; br_d = 0;
      do_reset();
      br_d = 1;
      wait_tick(); wait_tick(); wait_tick();
      en_d = 0;
      x0 = bus.x_barra;
      for (int i = 0; i < 3; i++) begin
         wait_tick();
         n_run++; if (bus.x_barra !== x0) begin n_fail++; $display("FAIL pause_x[%0d]: got %0d want %0d", i, bus.x_barra, x0); end
         n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL pause_moving[%0d]: got %b want 0", i, bus.moving); end
      end
      en_d = 1;
   endtask

   task automatic test_reset_mid();
      br_d = 1;
      for (int i = 0; i < 60 && m_x < 600; i++) wait_tick();
      n_run++; if (bus.x_barra < 11'd600) begin n_fail++; $display("FAIL premid_x: got %0d want >=600", bus.x_barra); end
      cyc(); cyc();
      vc = 200; rst_d = 1;
      cyc();
      rst_d = 0;
      n_run++; if (bus.x_barra !== 11'd501) begin n_fail++; $display("FAIL mid_reset_x: got %0d want 501", bus.x_barra); end
      n_run++; if (bus.moving !== 1'b0) begin n_fail++; $display("FAIL mid_reset_moving: got %b want 0", bus.moving); end
      br_d = 0;
   endtask

   task automatic test_random();
      bl_d = 0; br_d = 0; en_d = 1;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) bl_d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) br_d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) en_d = ~en_d;
         cyc();
         n_run++; if (bus.x_barra !== 11'(m_x)) begin n_fail++; $display("FAIL rand_x@%0d: got %0d want %0d", i, bus.x_barra, m_x); end
         n_run++; if (bus.moving !== m_moving) begin n_fail++; $display("FAIL rand_moving@%0d: got %b want %b", i, bus.moving, m_moving); end
         n_run++; if (bus.hit_wall !== m_hit) begin n_fail++; $display("FAIL rand_hit@%0d: got %b want %b", i, bus.hit_wall, m_hit); end
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.enable    = 1'b1;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.v_counter = 10'd1;
      test_reset();
      test_right_accel();
      test_left_wall();
      test_reverse();
      test_glitch();
      test_enable();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
